// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - round life-cycle, speed and score sequencing for the bounce-ball renderer
module game_flow_ctrl #(
    parameter int DB_CYCLES    = 1000000,
    parameter int LIVES        = 3,
    parameter int SPEED_INIT   = 2,
    parameter int SPEED_MAX    = 8,
    parameter int LEVEL_STEP   = 100,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        lose,
    input  logic [15:0] grade,
    output logic [7:0]  speed,
    output logic        round_rst,
    output logic [1:0]  lives,
    output logic [3:0]  level,
    output logic [2:0]  state,
    output logic        game_over,
    output logic [15:0] total_score
);

    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int FMAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [FW-1:0]  SERVE_LAST = FW'(SERVE_FRAMES - 1);
    localparam logic [FW-1:0]  OVER_SAT   = FW'(OVER_FRAMES);
    localparam logic [7:0]     SPD_INIT   = 8'(SPEED_INIT);
    localparam logic [7:0]     SPD_MAX    = 8'(SPEED_MAX);
    localparam logic [16:0]    STEP       = 17'(LEVEL_STEP);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_LOSE  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // bit order: 0 = vs, 1 = btn_start, 2 = btn_pause, 3 = lose
    logic [3:0] sync_m;
    logic [3:0] sync_s;
    logic       vs_d;
    logic       frame_tick;
    logic       lose_s;

    // bit order: 0 = start, 1 = pause
    logic [1:0]          btn_db;
    logic [1:0]          btn_press;
    logic [1:0][DBW-1:0] db_cnt;

    state_t      state_q, state_n;
    logic [FW-1:0] cnt_q, cnt_n;
    logic [1:0]  lives_q, lives_n;
    logic [3:0]  level_q, level_n;
    logic [15:0] bank_q, bank_n;
    logic [15:0] gq_q, gq_n;
    logic [15:0] grade_cap;
    logic [15:0] score_cap;
    logic [7:0]  spd_q, spd_n;
    logic [16:0] thresh_q, thresh_n;
    logic [7:0]  speed_n;
    logic        round_rst_n;
    logic        game_over_n;
    logic [15:0] total_n;

    // two-flop synchronisers for every asynchronous input, plus vs edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_m <= '0;
            sync_s <= '0;
            vs_d   <= 1'b0;
        end else begin
            sync_m <= {lose, btn_pause, btn_start, vs};
            sync_s <= sync_m;
            vs_d   <= sync_s[0];
        end
    end

    assign frame_tick = sync_s[0] & ~vs_d;
    assign lose_s     = sync_s[3];

    // debounce: level follows the input only after DB_CYCLES stable cycles; press pulses on rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db    <= '0;
            btn_press <= '0;
            db_cnt    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                btn_press[i] <= 1'b0;
                if (sync_s[i+1] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]    <= '0;
                    btn_db[i]    <= sync_s[i+1];
                    btn_press[i] <= sync_s[i+1];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // state, game registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lives_q     <= LIVES_INIT;
            level_q     <= '0;
            bank_q      <= '0;
            gq_q        <= '0;
            spd_q       <= SPD_INIT;
            thresh_q    <= STEP;
            speed       <= '0;
            round_rst   <= 1'b1;
            game_over   <= 1'b0;
            total_score <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            lives_q     <= lives_n;
            level_q     <= level_n;
            bank_q      <= bank_n;
            gq_q        <= gq_n;
            spd_q       <= spd_n;
            thresh_q    <= thresh_n;
            speed       <= speed_n;
            round_rst   <= round_rst_n;
            game_over   <= game_over_n;
            total_score <= total_n;
        end
    end

    assign state = state_q;
    assign lives = lives_q;
    assign level = level_q;

    // next-state, game bookkeeping and output decode
    always_comb begin
        // grade is only meaningful while a round is live; in LOSE/OVER/IDLE the
        // renderer still shows a stale or reset score that must not be banked twice
        grade_cap = gq_q;
        if (frame_tick && (state_q == S_SERVE || state_q == S_PLAY || state_q == S_PAUSE)) begin
            grade_cap = grade;
        end
        score_cap = sat16(bank_q, grade_cap);

        state_n  = state_q;
        cnt_n    = cnt_q;
        lives_n  = lives_q;
        level_n  = level_q;
        bank_n   = bank_q;
        gq_n     = grade_cap;
        spd_n    = spd_q;
        thresh_n = thresh_q;

        case (state_q)
            S_IDLE: begin
                if (btn_press[0]) begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_n = S_PLAY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (lose_s) begin
                    // round score moves into the bank; the live copy restarts at zero
                    state_n = S_LOSE;
                    bank_n  = score_cap;
                    gq_n    = '0;
                    lives_n = lives_q - 2'd1;
                end else begin
                    if (btn_press[1]) begin
                        state_n = S_PAUSE;
                    end
                    if (frame_tick && ({1'b0, score_cap} >= thresh_q) && (level_q != 4'd15)) begin
                        level_n  = level_q + 4'd1;
                        thresh_n = thresh_q + STEP;
                        spd_n    = (spd_q < SPD_MAX) ? spd_q + 8'd1 : SPD_MAX;
                    end
                end
            end
            S_PAUSE: begin
                if (btn_press[1]) begin
                    state_n = S_PLAY;
                end
            end
            S_LOSE: begin
                if (frame_tick) begin
                    state_n = (lives_q == 2'd0) ? S_OVER : S_SERVE;
                    cnt_n   = '0;
                end
            end
            S_OVER: begin
                if (frame_tick && cnt_q != OVER_SAT) begin
                    cnt_n = cnt_q + 1'b1;
                end
                if (btn_press[0] && cnt_q == OVER_SAT) begin
                    state_n  = S_SERVE;
                    cnt_n    = '0;
                    lives_n  = LIVES_INIT;
                    level_n  = '0;
                    bank_n   = '0;
                    gq_n     = '0;
                    spd_n    = SPD_INIT;
                    thresh_n = STEP;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        speed_n     = (state_n == S_PLAY) ? spd_n : 8'd0;
        round_rst_n = (state_n == S_IDLE) || (state_n == S_SERVE) || (state_n == S_OVER);
        game_over_n = (state_n == S_OVER);
        total_n     = sat16(bank_n, gq_n);
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench for game_flow_ctrl against an event-level game model
module tb_game_flow_ctrl;

    localparam int DB    = 4;
    localparam int SF    = 3;
    localparam int OF    = 5;
    localparam int LV    = 3;
    localparam int STEP  = 100;
    localparam int SP0   = 2;
    localparam int SPMAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic        btn_start;
    logic        btn_pause;
    logic        lose;
    logic [15:0] grade;
    logic [7:0]  speed;
    logic        round_rst;
    logic [1:0]  lives;
    logic [3:0]  level;
    logic [2:0]  state;
    logic        game_over;
    logic [15:0] total_score;

    int total = 0;
    int bad   = 0;

    // game model: state 0..5 as exposed on the state port
    int m_state, m_lives, m_level, m_bank, m_gq, m_spd, m_thresh, m_frames;

    game_flow_ctrl #(
        .DB_CYCLES(DB), .LIVES(LV), .SPEED_INIT(SP0), .SPEED_MAX(SPMAX),
        .LEVEL_STEP(STEP), .SERVE_FRAMES(SF), .OVER_FRAMES(OF)
    ) dut (
        .clk(clk), .rst(rst), .vs(vs), .btn_start(btn_start), .btn_pause(btn_pause),
        .lose(lose), .grade(grade), .speed(speed), .round_rst(round_rst), .lives(lives),
        .level(level), .state(state), .game_over(game_over), .total_score(total_score)
    );

    always #5 clk = ~clk;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".state"}, 32'(state), 32'(m_state));
        cmp({tag, ".speed"}, 32'(speed), 32'((m_state == 2) ? m_spd : 0));
        cmp({tag, ".round_rst"}, 32'(round_rst), 32'((m_state == 0 || m_state == 1 || m_state == 5) ? 1 : 0));
        cmp({tag, ".lives"}, 32'(lives), 32'(m_lives));
        cmp({tag, ".level"}, 32'(level), 32'(m_level));
        cmp({tag, ".game_over"}, 32'(game_over), 32'((m_state == 5) ? 1 : 0));
        cmp({tag, ".total"}, 32'(total_score), 32'(min2(m_bank + m_gq, 65535)));
    endtask

    task automatic m_reset();
        m_state = 0; m_lives = LV; m_level = 0; m_bank = 0; m_gq = 0;
        m_spd = SP0; m_thresh = STEP; m_frames = 0;
    endtask

    task automatic m_frame(input int g);
        case (m_state)
            1: begin
                m_gq = g;
                m_frames++;
                if (m_frames == SF) begin m_state = 2; m_frames = 0; end
            end
            2: begin
                m_gq = g;
                if (min2(m_bank + m_gq, 65535) >= m_thresh && m_level < 15) begin
                    m_level++;
                    m_thresh += STEP;
                    m_spd = min2(m_spd + 1, SPMAX);
                end
            end
            3: m_gq = g;
            4: begin m_state = (m_lives == 0) ? 5 : 1; m_frames = 0; end
            5: m_frames = min2(m_frames + 1, OF);
            default: ;
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int g);
        grade = 16'(g);
        cyc(2);
        vs = 1'b1;
        cyc(5);
        vs = 1'b0;
        cyc(5);
        m_frame(g);
    endtask

    task automatic press_start();
        btn_start = 1'b1; cyc(8);
        btn_start = 1'b0; cyc(8);
        if (m_state == 0) begin
            m_state = 1; m_frames = 0;
        end else if (m_state == 5 && m_frames == OF) begin
            m_reset();
            m_state = 1;
        end
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; cyc(8);
        btn_pause = 1'b0; cyc(8);
        if (m_state == 2) m_state = 3;
        else if (m_state == 3) m_state = 2;
    endtask

    task automatic set_lose(input logic v);
        lose = v;
        cyc(5);
        if (v && m_state == 2) begin
            m_bank  = min2(m_bank + m_gq, 65535);
            m_gq    = 0;
            m_lives = m_lives - 1;
            m_state = 4;
        end
    endtask

    task automatic serve_to_play();
        for (int i = 0; i < SF; i++) frame(0);
    endtask

    initial begin
        int g;
        rst = 1'b1; vs = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; lose = 1'b0; grade = '0;
        m_reset();
        cyc(3);
        check_all("in_reset");
        rst = 1'b0;
        cyc(2);
        check_all("after_reset");

        for (int i = 0; i < 10; i++) frame(int'($urandom_range(0, 500)));
        check_all("idle_10_frames");

        btn_start = 1'b1; cyc(3); btn_start = 1'b0; cyc(10);
        check_all("start_glitch");

        press_start();
        check_all("serve_entry");
        frame(0); frame(0);
        check_all("serve_2_ticks");
        frame(0);
        check_all("play_entry");

        frame(100);
        check_all("level_1");
        frame(250);
        check_all("level_2");
        frame(250);
        check_all("level_hold");

        for (int i = 0; i < 8; i++) begin
            g = m_thresh - m_bank + int'($urandom_range(0, 150));
            frame(g);
            check_all("level_rand");
        end
        cmp("speed_saturated", 32'(speed), 32'(SPMAX));

        frame(40);
        check_all("grade_40");
        set_lose(1'b1);
        check_all("lose_1");
        set_lose(1'b0);
        frame(0);
        check_all("lose_to_serve");

        serve_to_play();
        check_all("replay");
        frame(int'($urandom_range(0, 90)));
        check_all("replay_grade");
        press_pause();
        check_all("paused");
        set_lose(1'b1);
        check_all("lose_in_pause");
        frame(int'($urandom_range(0, 90)));
        check_all("pause_grade");
        set_lose(1'b0);
        press_pause();
        check_all("resumed");

        // pause press and synchronised lose land on the same cycle
        btn_pause = 1'b1;
        cyc(4);
        lose = 1'b1;
        cyc(8);
        btn_pause = 1'b0;
        cyc(8);
        if (m_state == 2) begin
            m_bank  = min2(m_bank + m_gq, 65535);
            m_gq    = 0;
            m_lives = m_lives - 1;
            m_state = 4;
        end
        check_all("pause_and_lose");
        set_lose(1'b0);
        frame(0);
        check_all("serve_after_lose2");

        serve_to_play();
        frame(int'($urandom_range(0, 90)));
        check_all("last_life_play");
        set_lose(1'b1);
        check_all("last_life_lose");
        set_lose(1'b0);
        frame(0);
        check_all("over_entry");
        frame(0); frame(0);
        press_start();
        check_all("over_start_early");
        frame(0); frame(0); frame(0);
        check_all("over_saturated");
        press_start();
        check_all("new_game");

        serve_to_play();
        frame(int'($urandom_range(0, 90)));
        check_all("mid_play");
        rst = 1'b1;
        #1;
        m_reset();
        check_all("async_reset");
        cyc(3);
        rst = 1'b0;
        cyc(2);
        check_all("reset_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Game-sequencing controller for the VGA bounce-ball renderer.
- Owns the round life-cycle: idle, serve countdown, play, pause, life loss and game over.
- Drives the renderer's reset and ball/bar speed, and raises speed with score.
- Banks per-round score across lives and exposes lives, level, state and total score to the display/7-seg logic.

Parameters:
DB_CYCLES, 1000000, button debounce stability window in clk cycles (10 ms at 100 MHz)
LIVES, 3, lives per game (legal 1..3)
SPEED_INIT, 2, speed at game start (1..255)
SPEED_MAX, 8, speed saturation value (>= SPEED_INIT)
LEVEL_STEP, 100, total-score points per level
SERVE_FRAMES, 60, frame ticks spent in SERVE
OVER_FRAMES, 180, frame ticks in OVER before start is accepted

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous active-high reset
vs  in  1  renderer vertical sync, asynchronous to clk
btn_start  in  1  raw start push-button, active-high
btn_pause  in  1  raw pause push-button, active-high
lose  in  1  renderer fail level, asynchronous, held until renderer reset
grade  in  16  renderer per-round score, changes only near falling vs
speed  out  8  speed to renderer; 0 freezes motion
round_rst  out  1  active-high reset to renderer
lives  out  2  remaining lives
level  out  4  current level
state  out  3  IDLE=0 SERVE=1 PLAY=2 PAUSE=3 LOSE=4 OVER=5
game_over  out  1  high in OVER
total_score  out  16  bank + grade_q, saturating at 16'hFFFF

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state=IDLE, round_rst=1, speed=0, lives=LIVES, level=0, game_over=0, total_score=0, bank=0, speed_reg=SPEED_INIT, thresh=LEVEL_STEP, frame counter=0, all synchronisers and debouncers cleared.
- Synchronisers:
  - vs, lose, btn_start and btn_pause each pass through a 2-FF synchroniser.
  - frame_tick is a 1-clk pulse on the synchronised rising edge of vs.
  - grade_q captures grade on frame_tick, so grade is sampled about half a frame after it changes.
- Debounce:
  - The debounced level updates only after the synchronised input has been stable for DB_CYCLES consecutive cycles.
  - A press is a 1-clk pulse on the debounced rising edge. Release generates no pulse.
- Outputs:
  - All outputs are registered.
  - speed = speed_reg only in PLAY, otherwise 0.
  - round_rst = 1 in IDLE, SERVE and OVER, 0 otherwise.
- State transitions:
  - IDLE: start press → SERVE; frame counter is cleared.
  - SERVE: frame counter increments on frame_tick. On the tick where the counter reaches SERVE_FRAMES-1 → PLAY and the counter clears.
  - PLAY, precedence lose > pause:
    - Synchronised lose=1 → LOSE. That same cycle: bank = sat16(bank + grade_q) and lives decrements.
    - Otherwise, pause press → PAUSE.
  - PAUSE: pause press → PLAY. Start press and lose are ignored. grade_q keeps updating.
  - LOSE: on the next frame_tick, lives==0 → OVER, else → SERVE. round_rst is asserted on entry to SERVE, which clears the renderer fail and grade.
  - OVER: frame counter counts ticks up to OVER_FRAMES and then saturates.
    - Start press before saturation is ignored.
    - Start press after saturation re-initialises lives, level, bank, speed_reg, thresh and the counter to their reset values, then → SERVE.
- Level-up, evaluated on frame_tick in PLAY only:
  - If sat16(bank + grade_q) >= thresh and level < 15: level+1, thresh += LEVEL_STEP, speed_reg = min(speed_reg+1, SPEED_MAX).
  - At most one level per tick.
  - thresh is 17 bits; once thresh > 16'hFFFF, no further levels.
- Lives never underflow: LOSE is reachable only with lives >= 1.
- Score and level persist across lives; only a new game clears them.
- Edge cases:
  - A press on the same cycle as a state transition applies in the new state only from the next press.
  - rst mid-operation returns immediately to reset values.

Test Plan:
- Bench settings: DB_CYCLES=4, SERVE_FRAMES=3, OVER_FRAMES=5, LIVES=3, LEVEL_STEP=100.
- Reset released, no stimulus → state=0, round_rst=1, speed=0, lives=3, level=0, total_score=0, stable for 10 frames. A 3-cycle start glitch gives no transition.
- Start held 6 cycles → state=1. After the 3rd vs rising edge → state=2, round_rst=0, speed=2.
- PLAY, grade=100 at tick → level=1, speed=3. grade=250 at next tick → level=2, speed=4. Grade held at 250 → level stays 2. Speed saturates at 8 after 6 level-ups.
- PLAY with bank=0, grade=40, then lose=1 → state=4, lives=2, total_score=40. Next tick → state=1, speed=0, round_rst=1.
- Pause press in PLAY → state=3, speed=0. Lose asserted in PAUSE is ignored. Second press → state=2, speed restored. Pause and lose on the same cycle → LOSE.
- lives=1, lose → LOSE then OVER, game_over=1. Start at tick 2 is ignored. Start after 5 ticks → state=1, lives=3, level=0, total_score=0. rst asserted mid-PLAY → reset values in the same cycle.
